hpm_counter_unit: RTL and testbench
===================================

Name: hpm_counter_unit

Overview:
Hardware performance-monitor counter bank that consumes the per-cycle performance event pulses raised by the core's pipeline stages. These are the same conditions the team feeds to its simulation PERF counters. The block selects events into programmable 64-bit counters and exposes them to the CSR unit as mhpmcounter3+/mhpmcounterh3+, mhpmevent3+ and mcountinhibit. It sits between the event sources (frontend, LSU, caches, ROB) and the CSR file, and works in synthesis, not only under DIFFTEST.

Parameters:
EVENT_NUM, 32, number of event inputs; event id 0 is reserved as "no event"
COUNTER_NUM, 8, number of programmable counters (hpm3 .. hpm3+COUNTER_NUM-1), max 29
INC_WIDTH, 3, width of each event's per-cycle increment (up to 7 per cycle for multi-issue events)
CNT_WIDTH, 64, counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
events_i  in  EVENT_NUM*INC_WIDTH  per-event increment this cycle; slot 0 is ignored
csr_we_i  in  1  CSR write strobe
csr_waddr_i  in  12  CSR write address
csr_wdata_i  in  32  CSR write data
csr_re_i  in  1  CSR read strobe
csr_raddr_i  in  12  CSR read address
csr_rdata_o  out  32  read data, registered
csr_rvalid_o  out  1  read data valid
csr_rerr_o  out  1  address not owned by this block, qualified by rvalid
ovf_o  out  COUNTER_NUM  sticky per-counter overflow flags

Behaviour:
- Reset values:
  - counters = 0, selectors = 0, inhibit bits = 0, ovf_o = 0
  - csr_rdata_o = 0, csr_rvalid_o = 0, csr_rerr_o = 0
  - event pipeline register = 0
- Address map:
  - mcountinhibit 0x320, bits [3 +: COUNTER_NUM] only; all other bits read 0 and writes to them are ignored
  - mhpmevent(3+i) at 0x323+i
  - mhpmcounter(3+i) at 0xB03+i (low 32 bits)
  - mhpmcounterh(3+i) at 0xB83+i (high 32 bits)
- Stage 1 (E): events_i is registered into events_q unconditionally.
- Stage 2 (C):
  - inc_i = events_q[sel_i] when 0 < sel_i < EVENT_NUM and inhibit[i] = 0; otherwise 0.
  - counter_i <= counter_i + zero-extended inc_i.
  - Event-to-count latency is 2 cycles: a pulse at cycle t is visible to a read issued at cycle t+2.
- Overflow:
  - When counter + inc carries out of CNT_WIDTH bits, the counter keeps the wrapped value and ovf_o[i] is set.
  - ovf_o[i] is sticky and clears on any CSR write to counter i's low or high half.
- Selector handling: selector writes store csr_wdata_i[7:0]; any value >= EVENT_NUM reads back as written but counts nothing.
- CSR write vs increment in the same cycle:
  - The write wins for the written half.
  - That counter's increment for the cycle is discarded; the other half keeps its old value.
  - Increments already in events_q for later cycles count normally.
- Selector or inhibit write: takes effect for the increment computed in the next cycle. The current cycle uses the old value.
- Reads:
  - The address is decoded in the csr_re_i cycle; rdata/rvalid/rerr are registered and appear 1 cycle later.
  - Returned data is the register value at the start of the request cycle, i.e. before that cycle's update.
  - Unmapped address: rdata = 0, rerr = 1.
  - Without csr_re_i, rvalid drops to 0 and rdata holds its last value.
- No high/low snapshot: software uses the standard RV32 hi-lo-hi re-read sequence.
- Read and write to the same address in one cycle: the read returns the old value.
- Reset mid-operation: all state clears asynchronously. The in-flight events_q is discarded, and events_i in the release cycle is captured normally.

Decomposition:
- Package perf_pkg holds:
  - enum PerfEvent (event ids, 0 = PERF_NONE)
  - CSR address constants: CSR_MCOUNTINHIBIT, CSR_MHPMEVENT3, CSR_MHPMCOUNTER3, CSR_MHPMCOUNTERH3
  - typedef hpm_inc_t of INC_WIDTH bits
- Sub-module hpm_counter: one counter slice (64-bit register, selector mux input, inhibit, write-half override, carry-out to the overflow flag). It is instantiated COUNTER_NUM times by the top, which owns the E-stage register, address decode and read mux.

Test Plan:
- Basic count: sel3 = 5; drive events_i[5] = 1 for 10 cycles; read 0xB03 at the cycle of the last pulse + 2 -> rdata = 10, rerr = 0. Counter 4 with sel = 0 reads 0.
- Multi-increment: events_i[7] = 7 for 4 cycles with hpm3 and hpm4 both selecting 7 -> both counters read 28.
- Inhibit: mcountinhibit = 0x8 while event 5 pulses 6 cycles -> hpm3 unchanged, hpm4 (same event) += 6. Writing 0x320 with 0xFFFF_FFFF reads back (2^COUNTER_NUM - 1) << 3.
- Overflow/wrap: write 0xB83 = 0xFFFF_FFFF and 0xB03 = 0xFFFF_FFFE, then event inc 3 -> low = 1, high = 0, ovf_o[0] = 1. A subsequent write to 0xB03 clears it.
- Write collision: a write to 0xB03 = 100 in the same cycle a selected increment lands -> reads 100. The next cycle's inc 2 -> reads 102.
- Errors/reset: read 0xB20 -> rvalid = 1, rerr = 1, rdata = 0. Assert rst mid-count -> all counters, ovf_o and rvalid return to 0 immediately.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared event ids, CSR addresses and increment type for the HPM counter bank.
// Event ids match the simulation PERF counter sources; id 0 never counts.
package perf_pkg;

  localparam int PERF_INC_WIDTH = 3;

  typedef logic [PERF_INC_WIDTH-1:0] hpm_inc_t;

  typedef enum logic [4:0] {
    PERF_NONE               = 5'd0,
    PERF_FRONTEND_FETCH     = 5'd1,
    PERF_FRONTEND_BUBBLE    = 5'd2,
    PERF_FRONTEND_FLUSH     = 5'd3,
    PERF_LSU_LOAD           = 5'd4,
    PERF_LSU_STORE          = 5'd5,
    PERF_LSU_REPLAY         = 5'd6,
    PERF_ROB_COMMIT         = 5'd7,
    PERF_ROB_FULL           = 5'd8,
    PERF_ICACHE_MISS        = 5'd9,
    PERF_DCACHE_MISS        = 5'd10,
    PERF_L2_MISS            = 5'd11,
    PERF_BRANCH_MISPREDICT  = 5'd12
  } PerfEvent;

  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MHPMCOUNTERH3 = 12'hB83;

endpackage

// File: rtl/hpm_counter.sv
// One 64-bit counter slice: event select, inhibit, CSR half-write override, sticky overflow.
// A CSR write to either half discards this cycle's increment and clears the overflow flag.
module hpm_counter
  import perf_pkg::*;
#(
  parameter int EVENT_NUM = 32,
  parameter int INC_WIDTH = PERF_INC_WIDTH,
  parameter int CNT_WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [EVENT_NUM*INC_WIDTH-1:0] i_events_q,
  input  logic [7:0]                     i_sel,
  input  logic                           i_inhibit,
  input  logic                           i_we_lo,
  input  logic                           i_we_hi,
  input  logic [31:0]                    i_wdata,
  output logic [CNT_WIDTH-1:0]           o_cnt,
  output logic                           o_ovf
);

  logic [INC_WIDTH-1:0] w_inc;
  logic [CNT_WIDTH:0]   w_sum;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;

  // Selector 0 and out-of-range selectors match no slot, so they count nothing.
  always_comb begin
    w_inc = '0;
    for (int e = 0; e < EVENT_NUM; e++) begin
      if (i_sel == 8'(e) && i_sel != 8'd0 && !i_inhibit)
        w_inc = i_events_q[e*INC_WIDTH +: INC_WIDTH];
    end
  end

  assign w_sum = {1'b0, r_cnt} + {{(CNT_WIDTH+1-INC_WIDTH){1'b0}}, w_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_we_lo) begin
      r_cnt[31:0] <= i_wdata;
      r_ovf       <= 1'b0;
    end else if (i_we_hi) begin
      r_cnt[CNT_WIDTH-1:32] <= i_wdata;
      r_ovf                 <= 1'b0;
    end else begin
      r_cnt <= w_sum[CNT_WIDTH-1:0];
      if (w_sum[CNT_WIDTH])
        r_ovf <= 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/hpm_counter_unit.sv
// HPM counter bank: registers event pulses, owns CSR decode and the registered read port.
// Event-to-count latency 2 cycles; reads return pre-update state one cycle after the request.
module hpm_counter_unit
  import perf_pkg::*;
#(
  parameter int EVENT_NUM   = 32,
  parameter int COUNTER_NUM = 8,
  parameter int INC_WIDTH   = PERF_INC_WIDTH,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [EVENT_NUM*INC_WIDTH-1:0] events_i,
  input  logic                           csr_we_i,
  input  logic [11:0]                    csr_waddr_i,
  input  logic [31:0]                    csr_wdata_i,
  input  logic                           csr_re_i,
  input  logic [11:0]                    csr_raddr_i,
  output logic [31:0]                    csr_rdata_o,
  output logic                           csr_rvalid_o,
  output logic                           csr_rerr_o,
  output logic [COUNTER_NUM-1:0]         ovf_o
);

  logic [EVENT_NUM*INC_WIDTH-1:0] r_events_q;
  logic [7:0]                     r_sel [COUNTER_NUM];
  logic [COUNTER_NUM-1:0]         r_inhibit;
  logic [CNT_WIDTH-1:0]           w_cnt [COUNTER_NUM];
  logic [COUNTER_NUM-1:0]         w_we_lo;
  logic [COUNTER_NUM-1:0]         w_we_hi;
  logic [COUNTER_NUM-1:0]         w_we_sel;
  logic                           w_we_inh;
  logic [31:0]                    w_rdata;
  logic                           w_rerr;
  logic [31:0]                    r_rdata;
  logic                           r_rvalid;
  logic                           r_rerr;

  always_comb begin
    w_we_inh = csr_we_i && (csr_waddr_i == CSR_MCOUNTINHIBIT);
    w_we_lo  = '0;
    w_we_hi  = '0;
    w_we_sel = '0;
    for (int i = 0; i < COUNTER_NUM; i++) begin
      w_we_sel[i] = csr_we_i && (csr_waddr_i == CSR_MHPMEVENT3    + 12'(i));
      w_we_lo[i]  = csr_we_i && (csr_waddr_i == CSR_MHPMCOUNTER3  + 12'(i));
      w_we_hi[i]  = csr_we_i && (csr_waddr_i == CSR_MHPMCOUNTERH3 + 12'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_events_q <= '0;
      r_inhibit  <= '0;
      for (int i = 0; i < COUNTER_NUM; i++)
        r_sel[i] <= '0;
    end else begin
      r_events_q <= events_i;
      if (w_we_inh)
        r_inhibit <= csr_wdata_i[3 +: COUNTER_NUM];
      for (int i = 0; i < COUNTER_NUM; i++)
        if (w_we_sel[i])
          r_sel[i] <= csr_wdata_i[7:0];
    end
  end

  for (genvar g = 0; g < COUNTER_NUM; g++) begin : g_cnt
    hpm_counter #(
      .EVENT_NUM (EVENT_NUM),
      .INC_WIDTH (INC_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_events_q (r_events_q),
      .i_sel      (r_sel[g]),
      .i_inhibit  (r_inhibit[g]),
      .i_we_lo    (w_we_lo[g]),
      .i_we_hi    (w_we_hi[g]),
      .i_wdata    (csr_wdata_i),
      .o_cnt      (w_cnt[g]),
      .o_ovf      (ovf_o[g])
    );
  end

  // Combinational view of current state, so a same-cycle write is not visible.
  always_comb begin
    w_rdata = '0;
    w_rerr  = 1'b1;
    if (csr_raddr_i == CSR_MCOUNTINHIBIT) begin
      w_rdata[3 +: COUNTER_NUM] = r_inhibit;
      w_rerr                    = 1'b0;
    end
    for (int i = 0; i < COUNTER_NUM; i++) begin
      if (csr_raddr_i == CSR_MHPMEVENT3 + 12'(i)) begin
        w_rdata = {24'd0, r_sel[i]};
        w_rerr  = 1'b0;
      end
      if (csr_raddr_i == CSR_MHPMCOUNTER3 + 12'(i)) begin
        w_rdata = w_cnt[i][31:0];
        w_rerr  = 1'b0;
      end
      if (csr_raddr_i == CSR_MHPMCOUNTERH3 + 12'(i)) begin
        w_rdata = w_cnt[i][CNT_WIDTH-1:32];
        w_rerr  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
    end else begin
      r_rvalid <= csr_re_i;
      if (csr_re_i) begin
        r_rdata <= w_rdata;
        r_rerr  <= w_rerr;
      end
    end
  end

  assign csr_rdata_o  = r_rdata;
  assign csr_rvalid_o = r_rvalid;
  assign csr_rerr_o   = r_rerr;

endmodule

// File: tb/tb_hpm_counter_unit.sv
// Directed bench for hpm_counter_unit: CSR readback table plus counting sequences.
module tb_hpm_counter_unit;

  localparam int EVENT_NUM   = 32;
  localparam int COUNTER_NUM = 8;
  localparam int INC_WIDTH   = 3;
  localparam int CNT_WIDTH   = 64;

  logic                           clk;
  logic                           rst;
  logic [EVENT_NUM*INC_WIDTH-1:0] events_i;
  logic                           csr_we_i;
  logic [11:0]                    csr_waddr_i;
  logic [31:0]                    csr_wdata_i;
  logic                           csr_re_i;
  logic [11:0]                    csr_raddr_i;
  logic [31:0]                    csr_rdata_o;
  logic                           csr_rvalid_o;
  logic                           csr_rerr_o;
  logic [COUNTER_NUM-1:0]         ovf_o;

  int checks = 0;
  int errors = 0;

  hpm_counter_unit #(
    .EVENT_NUM   (EVENT_NUM),
    .COUNTER_NUM (COUNTER_NUM),
    .INC_WIDTH   (INC_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .events_i     (events_i),
    .csr_we_i     (csr_we_i),
    .csr_waddr_i  (csr_waddr_i),
    .csr_wdata_i  (csr_wdata_i),
    .csr_re_i     (csr_re_i),
    .csr_raddr_i  (csr_raddr_i),
    .csr_rdata_o  (csr_rdata_o),
    .csr_rvalid_o (csr_rvalid_o),
    .csr_rerr_o   (csr_rerr_o),
    .ovf_o        (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_rerr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    csr_we_i    = 1'b1;
    csr_waddr_i = addr;
    csr_wdata_i = data;
    step();
    csr_we_i    = 1'b0;
  endtask

  task automatic rd(input string name, input logic [11:0] addr,
                    input logic [31:0] exp, input logic exp_err);
    csr_re_i    = 1'b1;
    csr_raddr_i = addr;
    step();
    csr_re_i    = 1'b0;
    chk({name, ".rvalid"}, 64'(csr_rvalid_o), 64'd1);
    chk({name, ".rdata"},  64'(csr_rdata_o),  64'(exp));
    chk({name, ".rerr"},   64'(csr_rerr_o),   64'(exp_err));
  endtask

  task automatic set_ev(input int slot, input logic [2:0] inc);
    events_i = '0;
    events_i[slot*INC_WIDTH +: INC_WIDTH] = inc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst         = 1'b1;
    events_i    = '0;
    csr_we_i    = 1'b0;
    csr_waddr_i = '0;
    csr_wdata_i = '0;
    csr_re_i    = 1'b0;
    csr_raddr_i = '0;

    vecs[0]  = '{12'h320, 32'hFFFF_FFFF, 32'h0000_07F8, 1'b0};
    vecs[1]  = '{12'h323, 32'h0000_01FF, 32'h0000_00FF, 1'b0};
    vecs[2]  = '{12'h324, 32'h0000_0040, 32'h0000_0040, 1'b0};
    vecs[3]  = '{12'h32A, 32'h0000_0011, 32'h0000_0011, 1'b0};
    vecs[4]  = '{12'hB03, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[5]  = '{12'hB83, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[6]  = '{12'hB0A, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0};
    vecs[7]  = '{12'hB8A, 32'h0000_ABCD, 32'h0000_ABCD, 1'b0};
    vecs[8]  = '{12'hB20, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
    vecs[9]  = '{12'h32B, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[10] = '{12'hB8B, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[11] = '{12'h321, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[12] = '{12'h320, 32'h0000_0000, 32'h0000_0000, 1'b0};

    #2;
    chk("reset.rdata",  64'(csr_rdata_o),  64'd0);
    chk("reset.rvalid", 64'(csr_rvalid_o), 64'd0);
    chk("reset.rerr",   64'(csr_rerr_o),   64'd0);
    chk("reset.ovf",    64'(ovf_o),        64'd0);
    step();
    rst = 1'b0;
    step();

    for (int v = 0; v < 13; v++) begin
      wr(vecs[v].addr, vecs[v].wdata);
      rd($sformatf("vec%0d", v), vecs[v].addr, vecs[v].exp_rdata, vecs[v].exp_rerr);
    end
    step();
    chk("idle.rvalid_drop", 64'(csr_rvalid_o), 64'd0);
    chk("idle.rdata_hold",  64'(csr_rdata_o),  64'd0);

    do_reset();
    rd("post_reset.b03", 12'hB03, 32'd0, 1'b0);
    rd("post_reset.sel", 12'h323, 32'd0, 1'b0);

    // Basic count: 10 pulses of event 5 into hpm3, read exactly 2 cycles after the last one.
    wr(12'h323, 32'd5);
    for (int c = 0; c < 10; c++) begin
      set_ev(5, 3'd1);
      step();
    end
    events_i = '0;
    step();
    rd("basic.hpm3", 12'hB03, 32'd10, 1'b0);
    rd("basic.hpm4", 12'hB04, 32'd0, 1'b0);

    // Multi-increment: two counters on the same 7-per-cycle event.
    wr(12'h323, 32'd7);
    wr(12'h324, 32'd7);
    wr(12'hB03, 32'd0);
    for (int c = 0; c < 4; c++) begin
      set_ev(7, 3'd7);
      step();
    end
    events_i = '0;
    step();
    rd("multi.hpm3", 12'hB03, 32'd28, 1'b0);
    rd("multi.hpm4", 12'hB04, 32'd28, 1'b0);

    // Inhibit hpm3 only.
    wr(12'h323, 32'd5);
    wr(12'h324, 32'd5);
    wr(12'hB03, 32'd0);
    wr(12'hB04, 32'd0);
    wr(12'h320, 32'h8);
    for (int c = 0; c < 6; c++) begin
      set_ev(5, 3'd1);
      step();
    end
    events_i = '0;
    step();
    rd("inhibit.hpm3", 12'hB03, 32'd0, 1'b0);
    rd("inhibit.hpm4", 12'hB04, 32'd6, 1'b0);
    wr(12'h320, 32'h0);
    rd("inhibit.clear", 12'h320, 32'd0, 1'b0);

    // Overflow: 0xFFFF_FFFF_FFFF_FFFE + 3 wraps to 1.
    wr(12'hB83, 32'hFFFF_FFFF);
    wr(12'hB03, 32'hFFFF_FFFE);
    set_ev(5, 3'd3);
    step();
    events_i = '0;
    step();
    chk("ovf.set", 64'(ovf_o), 64'h01);
    rd("ovf.low",  12'hB03, 32'd1, 1'b0);
    rd("ovf.high", 12'hB83, 32'd0, 1'b0);
    wr(12'hB03, 32'd0);
    chk("ovf.clear", 64'(ovf_o), 64'h00);

    // Write collision: the write lands with an inc of 3, next cycle's inc of 2 still counts.
    set_ev(5, 3'd3);
    step();
    set_ev(5, 3'd2);
    csr_we_i    = 1'b1;
    csr_waddr_i = 12'hB03;
    csr_wdata_i = 32'd100;
    step();
    csr_we_i = 1'b0;
    events_i = '0;
    rd("collide.write_wins", 12'hB03, 32'd100, 1'b0);
    rd("collide.next_inc",   12'hB03, 32'd102, 1'b0);

    // Read and write same address in one cycle returns the old value.
    csr_we_i    = 1'b1;
    csr_waddr_i = 12'h325;
    csr_wdata_i = 32'h33;
    csr_re_i    = 1'b1;
    csr_raddr_i = 12'h325;
    step();
    csr_we_i = 1'b0;
    csr_re_i = 1'b0;
    chk("rw_same.old", 64'(csr_rdata_o), 64'd0);
    rd("rw_same.new", 12'h325, 32'h33, 1'b0);

    // Reset mid-count with hpm4 overflowed and a read in flight.
    wr(12'hB84, 32'hFFFF_FFFF);
    wr(12'hB04, 32'hFFFF_FFFF);
    set_ev(5, 3'd1);
    step();
    step();
    step();
    chk("rst_mid.ovf_before", 64'(ovf_o[1]), 64'd1);
    csr_re_i    = 1'b1;
    csr_raddr_i = 12'hB03;
    step();
    chk("rst_mid.rvalid_before", 64'(csr_rvalid_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.ovf",    64'(ovf_o),        64'd0);
    chk("rst_mid.rvalid", 64'(csr_rvalid_o), 64'd0);
    chk("rst_mid.rdata",  64'(csr_rdata_o),  64'd0);
    csr_re_i = 1'b0;
    events_i = '0;
    step();
    rst = 1'b0;
    step();
    rd("rst_mid.hpm3", 12'hB03, 32'd0, 1'b0);
    rd("rst_mid.hpm4", 12'hB04, 32'd0, 1'b0);
    rd("rst_mid.sel4", 12'h324, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
